// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and constants for the FIFO burst reader.
package fifo_burst_reader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    CSUM   = 2'd2
  } state_e;

  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned OCC_W      = $clog2(SKID_DEPTH + 1);
  localparam int unsigned CNT_W      = 8;

endpackage

// File: rtl/burst_skid_buf.sv
// Two-entry in-order skid buffer; entry 0 is always the head beat.
module burst_skid_buf
  import fifo_burst_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic [OCC_W-1:0]      occ_o
);

  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
  logic [OCC_W-1:0]      occ_q;
  logic [OCC_W-1:0]      occ_d;

  // Next buffer contents; a simultaneous push and pop keeps occupancy constant.
  always_comb begin
    mem_d = mem_q;
    occ_d = occ_q;
    unique case ({push_i, pop_i})
      2'b10: begin
        if (occ_q == OCC_W'(0)) mem_d[0] = push_data_i;
        else                    mem_d[1] = push_data_i;
        occ_d = occ_q + OCC_W'(1);
      end
      2'b01: begin
        mem_d[0] = mem_q[1];
        occ_d    = occ_q - OCC_W'(1);
      end
      2'b11: begin
        if (occ_q == OCC_W'(1)) begin
          mem_d[0] = push_data_i;
        end else begin
          mem_d[0] = mem_q[1];
          mem_d[1] = push_data_i;
        end
      end
      default: ;
    endcase
  end

  // Buffer storage and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
      occ_q <= '0;
    end else begin
      mem_q <= mem_d;
      occ_q <= occ_d;
    end
  end

  assign head_data_o = mem_q[0];
  assign occ_o       = occ_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Reads a FIFO and emits fixed-length bursts on a valid/ready stream.
// Define FIFO_BURST_READER_CSUM_EN to append an XOR checksum beat to each burst.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                  r_clk,
  input  logic                  rst,
  output logic                  fifo_re,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
);

  state_e                state_q;
  state_e                state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic                  infl_q;
  logic [OCC_W-1:0]      occ;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  data_xfer;
  logic                  final_beat;
  logic [OCC_W:0]        level;

`ifdef FIFO_BURST_READER_CSUM_EN
  logic [DATA_WIDTH-1:0] xor_q;
  logic [DATA_WIDTH-1:0] xor_d;
`endif

  burst_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk_i       (r_clk),
    .rst_i       (rst),
    .push_i      (infl_q),
    .push_data_i (fifo_dout),
    .pop_i       (data_xfer),
    .head_data_o (head_data),
    .occ_o       (occ)
  );

  // Data beat handshake and read throttle; the level counts the slot freed by this cycle's pop.
  always_comb begin
    data_xfer  = (state_q != CSUM) && (occ != OCC_W'(0)) && m_ready;
    final_beat = data_xfer && (cnt_q == CNT_W'(BURST_LEN - 1));
    level      = (OCC_W + 1)'(occ) + (OCC_W + 1)'(infl_q) - (OCC_W + 1)'(data_xfer);
    fifo_re    = !rst && !fifo_empty && (state_q != CSUM) &&
                 (level < (OCC_W + 1)'(SKID_DEPTH));
  end

  // Next-state and beat counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty || (occ != OCC_W'(0)) || infl_q) state_d = STREAM;
      end
      STREAM: begin
`ifdef FIFO_BURST_READER_CSUM_EN
        if (final_beat) state_d = CSUM;
`else
        if (final_beat) state_d = IDLE;
`endif
      end
      CSUM: begin
        if (m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (data_xfer) cnt_d = final_beat ? CNT_W'(0) : cnt_q + CNT_W'(1);
  end

`ifdef FIFO_BURST_READER_CSUM_EN
  // Running XOR of the burst's data beats, cleared once the checksum beat leaves.
  always_comb begin
    xor_d = xor_q;
    if (data_xfer)                        xor_d = xor_q ^ head_data;
    else if ((state_q == CSUM) && m_ready) xor_d = '0;
  end
`endif

  // State, counter and in-flight read registers.
  always_ff @(posedge r_clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      infl_q  <= 1'b0;
`ifdef FIFO_BURST_READER_CSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      infl_q  <= fifo_re && !fifo_empty;
`ifdef FIFO_BURST_READER_CSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  // Stream outputs decoded from registered state.
  always_comb begin
    busy = (state_q != IDLE);
`ifdef FIFO_BURST_READER_CSUM_EN
    m_valid = (state_q == CSUM) || (occ != OCC_W'(0));
    m_data  = (state_q == CSUM) ? xor_q : head_data;
    m_last  = (state_q == CSUM);
`else
    m_valid = (occ != OCC_W'(0));
    m_data  = head_data;
    m_last  = (occ != OCC_W'(0)) && (cnt_q == CNT_W'(BURST_LEN - 1));
`endif
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural upstream FIFO.
module tb_fifo_burst_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned BL = 4;
`ifdef FIFO_BURST_READER_CSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  localparam int unsigned BPB = CS ? BL + 1 : BL;

  logic          r_clk = 1'b0;
  logic          rst;
  logic          fifo_re;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout = '0;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;

  int n_pass = 0;
  int n_chk  = 0;

  fifo_burst_reader #(
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL)
  ) dut (
    .r_clk      (r_clk),
    .rst        (rst),
    .fifo_re    (fifo_re),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy)
  );

  always #5 r_clk = ~r_clk;

  // Upstream FIFO: written by the stimulus, read one word per accepted read.
  logic [DW-1:0] fmem [256];
  int unsigned   wr_ptr = 0;
  int unsigned   rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge r_clk) begin
    if (fifo_re && !fifo_empty) begin
      fifo_dout <= fmem[8'(rd_ptr)];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Monitor: records transfers and tracks protocol invariants.
  logic [DW:0]   beats [$];
  int            outst = 0;
  int            occ_err = 0;
  int            re_viol = 0;
  int            stab_err = 0;
  int unsigned   bidx = 0;
  logic          prev_stall = 1'b0;
  logic [DW:0]   prev_beat = '0;

  wire acc_w  = fifo_re && !fifo_empty;
  wire xfer_w = m_valid && m_ready;
  wire csum_w = CS && (bidx == BL);
  wire dx_w   = xfer_w && !csum_w;

  always @(negedge r_clk) begin
    if (rst) begin
      outst      <= 0;
      bidx       <= 0;
      prev_stall <= 1'b0;
    end else begin
      if (fifo_re && fifo_empty) re_viol <= re_viol + 1;
      if (outst + int'(acc_w) - int'(dx_w) > 2) occ_err <= occ_err + 1;
      outst <= outst + int'(acc_w) - int'(dx_w);
      if (prev_stall && (!m_valid || ({m_last, m_data} !== prev_beat))) stab_err <= stab_err + 1;
      prev_stall <= m_valid && !m_ready;
      prev_beat  <= {m_last, m_data};
      if (xfer_w) begin
        beats.push_back({m_last, m_data});
        bidx <= (bidx == BPB - 1) ? 0 : bidx + 1;
      end
    end
  end

  task automatic cyc();
    @(posedge r_clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    fmem[8'(wr_ptr)] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_beats(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (beats.size() >= target) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    int bad_re = 0;
    int bad_v  = 0;
    int start;
    bit ok;
    rst = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'(i + 1));
    repeat (4) begin
      @(negedge r_clk);
      if (fifo_re !== 1'b0) bad_re++;
      if (m_valid !== 1'b0) bad_v++;
    end
    n_chk++; if (bad_re !== 0) $display("FAIL reset_fifo_re bad_cycles=%0d want 0", bad_re); else n_pass++;
    n_chk++; if (bad_v !== 0) $display("FAIL reset_m_valid bad_cycles=%0d want 0", bad_v); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_chk++; if (m_data !== 8'h00) $display("FAIL reset_m_data got %h want 00", m_data); else n_pass++;
    n_chk++; if (m_last !== 1'b0) $display("FAIL reset_m_last got %b want 0", m_last); else n_pass++;
    @(posedge r_clk); #1;
    rst = 1'b0;
    start = beats.size();
    wait_beats(start + 2 * BPB, ok);
    n_chk++; if (!ok) $display("FAIL reset_drain_timeout got %0d beats want %0d", beats.size() - start, 2 * BPB); else n_pass++;
    if (ok) begin
      n_chk++; if (beats[start] !== {1'b0, 8'h01}) $display("FAIL reset_first_beat got %h want 001", beats[start]); else n_pass++;
    end
    repeat (4) cyc();
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_drain_idle busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_burst();
    logic          ev [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, CS, 1'b0};
    logic [DW-1:0] ed [8] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44, 8'h00};
    logic          el [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, !CS, 1'b1, 1'b0};
    logic          eb [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, CS, 1'b0};
    logic          er [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    m_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    for (int c = 0; c < 8; c++) begin
      @(negedge r_clk);
      n_chk++; if (m_valid !== ev[c]) $display("FAIL burst_valid c%0d got %b want %b", c, m_valid, ev[c]); else n_pass++;
      n_chk++; if (busy !== eb[c]) $display("FAIL burst_busy c%0d got %b want %b", c, busy, eb[c]); else n_pass++;
      n_chk++; if (fifo_re !== er[c]) $display("FAIL burst_fifo_re c%0d got %b want %b", c, fifo_re, er[c]); else n_pass++;
      if (ev[c]) begin
        n_chk++; if (m_data !== ed[c]) $display("FAIL burst_data c%0d got %h want %h", c, m_data, ed[c]); else n_pass++;
        n_chk++; if (m_last !== el[c]) $display("FAIL burst_last c%0d got %b want %b", c, m_last, el[c]); else n_pass++;
      end
      @(posedge r_clk); #1;
    end
  endtask

  task automatic test_stall();
    int            start = beats.size();
    int            idx = 0;
    bit            ok = 1'b0;
    logic [DW-1:0] x;
    logic [DW-1:0] d;
    logic [DW:0]   exp;
    for (int i = 0; i < 8; i++) push(8'(8'h80 + i));
    for (int k = 0; k < 300; k++) begin
      if (beats.size() >= start + 2 * BPB) begin
        ok = 1'b1;
        break;
      end
      m_ready = ((k % 3) == 0);
      cyc();
    end
    m_ready = 1'b1;
    repeat (6) cyc();
    n_chk++; if (!ok) $display("FAIL stall_timeout got %0d beats want %0d", beats.size() - start, 2 * BPB); else n_pass++;
    n_chk++; if (beats.size() !== start + 2 * BPB) $display("FAIL stall_count got %0d want %0d", beats.size() - start, 2 * BPB); else n_pass++;
    if (ok) begin
      for (int b = 0; b < 2; b++) begin
        x = '0;
        for (int i = 0; i < BL; i++) begin
          d   = 8'(8'h80 + b * 4 + i);
          exp = {(i == BL - 1) && !CS, d};
          x   = x ^ d;
          n_chk++; if (beats[start + idx] !== exp) $display("FAIL stall_beat%0d got %h want %h", idx, beats[start + idx], exp); else n_pass++;
          idx++;
        end
        if (CS) begin
          n_chk++; if (beats[start + idx] !== {1'b1, x}) $display("FAIL stall_csum%0d got %h want %h", b, beats[start + idx], {1'b1, x}); else n_pass++;
          idx++;
        end
      end
    end
    n_chk++; if (stab_err !== 0) $display("FAIL stall_stable unstable_cycles=%0d want 0", stab_err); else n_pass++;
    n_chk++; if (occ_err !== 0) $display("FAIL stall_occupancy over2_cycles=%0d want 0", occ_err); else n_pass++;
    n_chk++; if (re_viol !== 0) $display("FAIL stall_re_on_empty cycles=%0d want 0", re_viol); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL stall_idle busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_gap();
    int            start = beats.size();
    int            gap_v = 0;
    int            gap_b = 0;
    bit            ok;
    logic [DW-1:0] x = '0;
    logic [DW-1:0] d;
    m_ready = 1'b1;
    push(8'h51); push(8'h52);
    repeat (4) cyc();
    repeat (5) begin
      @(negedge r_clk);
      if (m_valid !== 1'b0) gap_v++;
      if (busy !== 1'b1) gap_b++;
      @(posedge r_clk); #1;
    end
    n_chk++; if (gap_v !== 0) $display("FAIL gap_valid high_cycles=%0d want 0", gap_v); else n_pass++;
    n_chk++; if (gap_b !== 0) $display("FAIL gap_busy low_cycles=%0d want 0", gap_b); else n_pass++;
    push(8'h53); push(8'h54);
    wait_beats(start + BPB, ok);
    n_chk++; if (!ok) $display("FAIL gap_timeout got %0d beats want %0d", beats.size() - start, BPB); else n_pass++;
    if (ok) begin
      for (int i = 0; i < BL; i++) begin
        d = 8'(8'h51 + i);
        x = x ^ d;
        n_chk++; if (beats[start + i] !== {(i == BL - 1) && !CS, d}) $display("FAIL gap_beat%0d got %h want %h", i, beats[start + i], {(i == BL - 1) && !CS, d}); else n_pass++;
      end
      if (CS) begin
        n_chk++; if (beats[start + BL] !== {1'b1, x}) $display("FAIL gap_csum got %h want %h", beats[start + BL], {1'b1, x}); else n_pass++;
      end
    end
    repeat (4) cyc();
  endtask

  task automatic test_reset_midread();
    int            start;
    int            idx = 0;
    bit            ok;
    logic [DW-1:0] x;
    logic [DW-1:0] d;
    m_ready = 1'b1;
    for (int i = 0; i < 9; i++) push(8'(8'hA0 + i));
    @(negedge r_clk);
    n_chk++; if (fifo_re !== 1'b1) $display("FAIL midrst_read got %b want 1", fifo_re); else n_pass++;
    @(posedge r_clk); #1;
    rst = 1'b1;
    @(negedge r_clk);
    n_chk++; if (fifo_re !== 1'b0) $display("FAIL midrst_re_in_reset got %b want 0", fifo_re); else n_pass++;
    @(posedge r_clk); #1;
    rst = 1'b0;
    start = beats.size();
    wait_beats(start + 2 * BPB, ok);
    repeat (4) cyc();
    n_chk++; if (!ok) $display("FAIL midrst_timeout got %0d beats want %0d", beats.size() - start, 2 * BPB); else n_pass++;
    n_chk++; if (beats.size() !== start + 2 * BPB) $display("FAIL midrst_count got %0d want %0d", beats.size() - start, 2 * BPB); else n_pass++;
    if (ok) begin
      for (int b = 0; b < 2; b++) begin
        x = '0;
        for (int i = 0; i < BL; i++) begin
          d = 8'(8'hA1 + b * 4 + i);
          x = x ^ d;
          n_chk++; if (beats[start + idx] !== {(i == BL - 1) && !CS, d}) $display("FAIL midrst_beat%0d got %h want %h", idx, beats[start + idx], {(i == BL - 1) && !CS, d}); else n_pass++;
          idx++;
        end
        if (CS) begin
          n_chk++; if (beats[start + idx] !== {1'b1, x}) $display("FAIL midrst_csum%0d got %h want %h", b, beats[start + idx], {1'b1, x}); else n_pass++;
          idx++;
        end
      end
    end
    n_chk++; if (busy !== 1'b0) $display("FAIL midrst_idle busy got %b want 0", busy); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    m_ready = 1'b1;
    test_reset();
    test_burst();
    test_stall();
    test_gap();
    test_reset_midread();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
